add_seq_ctrl: RTL and testbench



---
 rtl/add_seq_ctrl.sv | 118 +++++++++++
 tb/tb_add_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_seq_ctrl.sv
// Multi-byte adder sequencer: time-shares one external 8-bit adder, LSB first.
// Optional `ADD_SEQ_SUB_EN adds a `sub` input for A - B (two's complement).
module add_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  cin,
`ifdef ADD_SEQ_SUB_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout_o,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic [W-1:0]    a_q, b_q, result_q;
  logic            carry_q, cout_q, busy_q, done_q, sub_q;
  logic [IW-1:0]   idx_q;
  logic            sub_in;
  logic [7:0]      byte_a, byte_b;

`ifdef ADD_SEQ_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  always_comb begin
    byte_a  = '0;
    byte_b  = '0;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IW'(i)) begin
        byte_a = a_q[8*i +: 8];
        byte_b = b_q[8*i +: 8];
      end
    end
    if (state_q == RUN) begin
      add_a   = byte_a;
      add_b   = sub_q ? ~byte_b : byte_b;
      add_cin = carry_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sub_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= op_a;
            b_q     <= op_b;
            sub_q   <= sub_in;
            // subtraction needs the +1 of the two's complement as initial carry
            carry_q <= sub_in | cin;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IW'(i)) result_q[8*i +: 8] <= add_sum;
          end
          carry_q <= add_cout;
          if (idx_q == LAST) begin
            cout_q  <= add_cout;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout_o = cout_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Bench for add_seq_ctrl: NBYTES=4 and NBYTES=1 instances against an arithmetic
// reference model, plus directed cases with literal expectations.
module tb_add_seq_ctrl;

`ifdef ADD_SEQ_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start0, cin0, sub0, busy0, done0, cout0, acin0, acout0;
  logic [31:0] opa0, opb0, res0;
  logic [7:0]  aa0, ab0, asum0;
  logic        start1, cin1, sub1, busy1, done1, cout1, acin1, acout1;
  logic [7:0]  opa1, opb1, res1, aa1, ab1, asum1;

  // external 8-bit adders
  assign {acout0, asum0} = 9'(aa0) + 9'(ab0) + 9'(acin0);
  assign {acout1, asum1} = 9'(aa1) + 9'(ab1) + 9'(acin1);

  add_seq_ctrl #(.NBYTES(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .op_a(opa0), .op_b(opb0), .cin(cin0),
`ifdef ADD_SEQ_SUB_EN
    .sub(sub0),
`endif
    .busy(busy0), .done(done0), .result(res0), .cout_o(cout0),
    .add_a(aa0), .add_b(ab0), .add_cin(acin0), .add_sum(asum0), .add_cout(acout0)
  );

  add_seq_ctrl #(.NBYTES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_a(opa1), .op_b(opb1), .cin(cin1),
`ifdef ADD_SEQ_SUB_EN
    .sub(sub1),
`endif
    .busy(busy1), .done(done1), .result(res1), .cout_o(cout1),
    .add_a(aa1), .add_b(ab1), .add_cin(acin1), .add_sum(asum1), .add_cout(acout1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // ph: 0 idle, 1..n running on byte ph-1, n+1 done
  int          ph[2];
  logic [63:0] ma[2], mb[2], eres[2];
  logic        mc[2], ecout[2];
  bit          rval[2];

  function automatic int nb(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic logic [63:0] wmask(input int k);
    return (64'd1 << (8 * nb(k))) - 64'd1;
  endfunction

  function automatic logic cin_at(input int k, input int j);
    logic [64:0] m, t;
    if (j == 0) return mc[k];
    m = (65'd1 << (8 * j)) - 65'd1;
    t = (65'(ma[k]) & m) + (65'(mb[k]) & m) + 65'(mc[k]);
    return t[8*j];
  endfunction

  task automatic model_step(input int k, input logic st, input logic [63:0] a, input logic [63:0] b,
                            input logic c, input logic s);
    logic [64:0] tot;
    int n;
    n = nb(k);
    if (ph[k] == 0) begin
      if (st) begin
        ma[k]   = a & wmask(k);
        mb[k]   = ((s && SUB_EN) ? ~b : b) & wmask(k);
        mc[k]   = (s && SUB_EN) ? 1'b1 : c;
        ph[k]   = 1;
        rval[k] = 1'b0;
      end
    end else if (ph[k] <= n) begin
      ph[k]++;
      if (ph[k] == n + 1) begin
        tot      = 65'(ma[k]) + 65'(mb[k]) + 65'(mc[k]);
        eres[k]  = tot[63:0] & wmask(k);
        ecout[k] = tot[8*n];
        rval[k]  = 1'b1;
      end
    end else begin
      ph[k] = 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        ph[k] = 0; ma[k] = '0; mb[k] = '0; mc[k] = 1'b0;
        eres[k] = '0; ecout[k] = 1'b0; rval[k] = 1'b1;
      end
    end else begin
      model_step(0, start0, 64'(opa0), 64'(opb0), cin0, sub0);
      model_step(1, start1, 64'(opa1), 64'(opb1), cin1, sub1);
    end
  end

  // ---------------- per-cycle compare ----------------
  bit         cap_en = 1'b0;
  logic [7:0] q_aa[$];
  bit         model_on = 1'b0;

  always @(negedge clk) begin : cmp
    int n, j;
    bit run;
    logic [63:0] a_res;
    logic a_busy, a_done, a_cout, a_cin;
    logic [7:0] a_aa, a_ab, e_aa, e_ab;
    if (cap_en && busy0 && !done0) q_aa.push_back(aa0);
    if (model_on) begin
      for (int k = 0; k < 2; k++) begin
        n = nb(k);
        run = (ph[k] >= 1) && (ph[k] <= n);
        j = run ? ph[k] - 1 : 0;
        a_busy = (k == 0) ? busy0 : busy1;
        a_done = (k == 0) ? done0 : done1;
        a_aa   = (k == 0) ? aa0 : aa1;
        a_ab   = (k == 0) ? ab0 : ab1;
        a_cin  = (k == 0) ? acin0 : acin1;
        a_res  = (k == 0) ? 64'(res0) : 64'(res1);
        a_cout = (k == 0) ? cout0 : cout1;
        e_aa = run ? 8'(ma[k] >> (8 * j)) : 8'h00;
        e_ab = run ? 8'(mb[k] >> (8 * j)) : 8'h00;
        chk($sformatf("d%0d busy", k), 64'(a_busy), 64'(ph[k] != 0));
        chk($sformatf("d%0d done", k), 64'(a_done), 64'(ph[k] == n + 1));
        chk($sformatf("d%0d add_a", k), 64'(a_aa), 64'(e_aa));
        chk($sformatf("d%0d add_b", k), 64'(a_ab), 64'(e_ab));
        chk($sformatf("d%0d add_cin", k), 64'(a_cin), run ? 64'(cin_at(k, j)) : 64'd0);
        if (rval[k]) begin
          chk($sformatf("d%0d result", k), a_res, eres[k]);
          chk($sformatf("d%0d cout_o", k), 64'(a_cout), 64'(ecout[k]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int k, input logic st, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic s);
    if (k == 0) begin
      start0 = st; opa0 = a; opb0 = b; cin0 = c; sub0 = s;
    end else begin
      start1 = st; opa1 = a[7:0]; opb1 = b[7:0]; cin1 = c; sub1 = s;
    end
  endtask

  // one operation; xs = RUN cycle for a stray start, rc = RUN cycle for a reset
  task automatic op(input int k, input logic [31:0] a, input logic [31:0] b, input logic c,
                    input logic s, input int xs, input int rc, output int lat, output int nd);
    int cnt;
    @(posedge clk); #1 drive(k, 1'b1, a, b, c, s);
    @(posedge clk); #1 drive(k, 1'b0, a, b, c, s);
    cnt = 1; lat = -1; nd = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc == xs) drive(k, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);
      else if (cyc == xs + 1) drive(k, 1'b0, a, b, c, s);
      if (cyc == rc) begin
        rst = 1'b1;
        #1;
        chk("rst busy", 64'(busy0), 64'd0);
        chk("rst done", 64'(done0), 64'd0);
        chk("rst result", 64'(res0), 64'd0);
        chk("rst cout_o", 64'(cout0), 64'd0);
        chk("rst add_a", 64'(aa0), 64'd0);
        chk("rst add_b", 64'(ab0), 64'd0);
        chk("rst add_cin", 64'(acin0), 64'd0);
      end
      @(posedge clk); #1;
      if (cyc == rc) rst = 1'b0;
      cnt++;
      if ((k == 0) ? done0 : done1) begin
        if (nd == 0) lat = cnt;
        nd++;
      end
    end
  endtask

  initial begin
    int lat, nd;
    drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    #1 rst = 1'b1;
    model_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset result", 64'(res0), 64'd0);
    chk("reset busy", 64'(busy0), 64'd0);

    op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 0, lat, nd);
    chk("ovf result", 64'(res0), 64'h0);
    chk("ovf cout", 64'(cout0), 64'd1);
    chk("ovf latency", 64'(lat), 64'd5);
    chk("ovf done pulses", 64'(nd), 64'd1);

    q_aa.delete();
    cap_en = 1'b1;
    op(0, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 0, 0, lat, nd);
    cap_en = 1'b0;
    chk("seq result", 64'(res0), 64'h2345_678A);
    chk("seq cout", 64'(cout0), 64'd0);
    chk("seq add_a count", 64'(q_aa.size()), 64'd4);
    if (q_aa.size() == 4) begin
      chk("seq add_a[0]", 64'(q_aa[0]), 64'h78);
      chk("seq add_a[1]", 64'(q_aa[1]), 64'h56);
      chk("seq add_a[2]", 64'(q_aa[2]), 64'h34);
      chk("seq add_a[3]", 64'(q_aa[3]), 64'h12);
    end

    op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 2, 0, lat, nd);
    chk("ign result", 64'(res0), 64'h100);
    chk("ign cout", 64'(cout0), 64'd0);
    chk("ign done pulses", 64'(nd), 64'd1);

    op(0, 32'h0A0B_0C0D, 32'h0101_0101, 1'b0, 1'b0, 0, 2, lat, nd);
    chk("rst done pulses", 64'(nd), 64'd0);
    op(0, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 0, 0, lat, nd);
    chk("post-rst result", 64'(res0), 64'h30);
    chk("post-rst done pulses", 64'(nd), 64'd1);

    op(1, 32'hFF, 32'hFF, 1'b1, 1'b0, 0, 0, lat, nd);
    chk("n1 result", 64'(res1), 64'hFF);
    chk("n1 cout", 64'(cout1), 64'd1);
    chk("n1 latency", 64'(lat), 64'd2);

`ifdef ADD_SEQ_SUB_EN
    op(0, 32'd5, 32'd7, 1'b0, 1'b1, 0, 0, lat, nd);
    chk("sub 5-7 result", 64'(res0), 64'hFFFF_FFFE);
    chk("sub 5-7 cout", 64'(cout0), 64'd0);
    op(0, 32'd7, 32'd5, 1'b0, 1'b1, 0, 0, lat, nd);
    chk("sub 7-5 result", 64'(res0), 64'h2);
    chk("sub 7-5 cout", 64'(cout0), 64'd1);
`endif

    // random traffic, including starts while busy and one mid-stream reset
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      drive(0, ($urandom_range(2) == 0), $urandom, $urandom, 1'($urandom), 1'($urandom));
      drive(1, ($urandom_range(2) == 0), $urandom, $urandom, 1'($urandom), 1'($urandom));
      if (cyc == 301) rst = 1'b1;
      if (cyc == 303) rst = 1'b0;
    end
    drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
